// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller: opcodes, datapath select encodings, FSM states.
// MULDIV_EN (optional) enables the M-extension path; the types below cover both builds.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SRL = 4'd3, ALU_SRA = 4'd4,
        ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_XOR = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
        BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6, BR_JUMP = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        WB_PC4 = 2'b00, WB_ALU = 2'b01, WB_MEM = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_TRAP = 3'd5, S_MULDIV = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_ALU = 3'd0, C_JUMP = 3'd1, C_BRANCH = 3'd2, C_LOAD = 3'd3,
        C_STORE = 3'd4, C_MULDIV = 3'd5
    } inst_class_e;

    typedef struct packed {
        inst_class_e cls;
        logic        sel_a;
        logic        sel_b;
        wb_sel_e     wb_sel;
        alu_op_e     alu_op;
        br_type_e    br_type;
    } ctrl_word_t;

    // alt selects SUB/SRA (instruction bit 30) where the encoding defines it.
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_inst_decoder.sv
// Combinational RV32I decoder: instruction word -> control word plus illegal-encoding flag.
// With MULDIV_EN defined, OP with funct7=0000001 decodes as a mul/div class instead of illegal.
module inst_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output ctrl_word_t  cw_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];
    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_fields = ^{ir_i[24:15], ir_i[11:7]};

    always_comb begin
        cw_o         = '0;
        cw_o.cls     = C_ALU;
        cw_o.sel_a   = 1'b1;
        cw_o.sel_b   = 1'b1;
        cw_o.wb_sel  = WB_ALU;
        cw_o.alu_op  = ALU_ADD;
        cw_o.br_type = BR_NONE;
        illegal_o    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                cw_o.sel_a  = 1'b0;
                cw_o.alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: cw_o.sel_a = 1'b0;
            OPC_JAL: begin
                cw_o.cls     = C_JUMP;
                cw_o.sel_a   = 1'b0;
                cw_o.wb_sel  = WB_PC4;
                cw_o.br_type = BR_JUMP;
            end
            OPC_JALR: begin
                cw_o.cls     = C_JUMP;
                cw_o.wb_sel  = WB_PC4;
                cw_o.br_type = BR_JUMP;
                illegal_o    = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                cw_o.cls   = C_BRANCH;
                cw_o.sel_a = 1'b0;
                case (funct3)
                    3'b000:  cw_o.br_type = BR_EQ;
                    3'b001:  cw_o.br_type = BR_NE;
                    3'b100:  cw_o.br_type = BR_LT;
                    3'b101:  cw_o.br_type = BR_GE;
                    3'b110:  cw_o.br_type = BR_LTU;
                    3'b111:  cw_o.br_type = BR_GEU;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                cw_o.cls    = C_LOAD;
                cw_o.wb_sel = WB_MEM;
                illegal_o   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                cw_o.cls  = C_STORE;
                illegal_o = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                cw_o.alu_op = f3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
                illegal_o   = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                              ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                cw_o.sel_b = 1'b0;
                if (funct7 == F7_BASE) begin
                    cw_o.alu_op = f3_to_alu(funct3, 1'b0);
                end else if (funct7 == F7_ALT) begin
                    cw_o.alu_op = f3_to_alu(funct3, 1'b1);
                    illegal_o   = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef MULDIV_EN
                end else if (funct7 == F7_MULDIV) begin
                    cw_o.cls = C_MULDIV;
`endif
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with illegal-instruction and bus-timeout traps.
// Define MULDIV_EN to add the MULDIV state and md_start/md_op/md_done ports.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ALU_OP_W    = 4,
    parameter int BR_TYPE_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic [31:0]          ir,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic                 reg_wr,
    output logic                 rd_en,
    output logic                 wr_en,
    output logic                 sel_A,
    output logic                 sel_B,
    output logic [1:0]           wb_sel,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [BR_TYPE_W-1:0] br_type,
    output logic                 illegal,
    output logic                 bus_err,
`ifdef MULDIV_EN
    input  logic                 md_done,
    output logic                 md_start,
    output logic [2:0]           md_op,
`endif
    output logic [2:0]           state_dbg_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    state_e             state_q, state_d;
    logic [31:0]        ir_q;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_word_t         cw;
    logic               dec_illegal;
    logic               req_wait;
    logic               timeout_hit;
    logic               in_ctrl;

    inst_decoder u_dec (
        .ir_i      (ir_q),
        .cw_o      (cw),
        .illegal_o (dec_illegal)
    );

    // Handshake: a req is raised on entry to FETCH/MEM (start pulse then done for MULDIV) and held
    // until the cycle its ack is seen; that cycle completes the transfer and the FSM moves on.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        reg_wr    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        req_wait  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                req_wait = !imem_ack;
                if (imem_ack) begin
                    ir_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cw.cls)
                    C_BRANCH: begin
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
`ifdef MULDIV_EN
                    C_MULDIV: state_d = S_MULDIV;
`endif
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                rd_en    = (cw.cls == C_LOAD);
                wr_en    = (cw.cls == C_STORE);
                req_wait = !dmem_ack;
                if (dmem_ack) begin
                    if (cw.cls == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_wr   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef MULDIV_EN
            S_MULDIV: begin
                req_wait = !md_done;
                if (md_done) state_d = S_WB;
            end
`endif
            S_WB: begin
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // An ack in the limit cycle clears req_wait, so it wins over the timeout.
        timeout_hit = (TIMEOUT_CYC > 0) && req_wait && (cnt_q == CNT_W'(LIMIT));
        if (timeout_hit) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end
        cnt_d = (req_wait && (TIMEOUT_CYC > 0)) ? cnt_q + CNT_W'(1) : '0;

        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_wr    = 1'b0;
            pc_wr    = 1'b0;
            reg_wr   = 1'b0;
            rd_en    = 1'b0;
            wr_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= NOP_INSN;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            if (ir_wr) ir_q <= imem_rdata;
        end
    end

`ifdef MULDIV_EN
    logic md_start_q;

    always_ff @(posedge clk) begin
        if (rst) md_start_q <= 1'b0;
        else     md_start_q <= (state_d == S_MULDIV) && (state_q != S_MULDIV);
    end

    assign md_start = md_start_q && !rst;
    assign md_op    = ir_q[14:12];
`endif

    assign in_ctrl = !rst && (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV});

    assign sel_A       = in_ctrl && cw.sel_a;
    assign sel_B       = in_ctrl && cw.sel_b;
    assign wb_sel      = in_ctrl ? cw.wb_sel : WB_PC4;
    assign alu_op      = in_ctrl ? ALU_OP_W'(cw.alu_op) : '0;
    assign br_type     = in_ctrl ? BR_TYPE_W'(cw.br_type) : '0;
    assign ir          = ir_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;
    assign state_dbg_o = state_q;

endmodule
